fetch_stage: RTL and testbench

- Instruction-fetch stage and IF/ID pipeline register of the RV32I core.
- Consumes the hazard unit's stall outputs (pc_write, ifid_write, ifid_clear) and the EX-stage branch/JALR redirect.
- Issues pipelined requests to instruction memory, buffers returned words in a small queue, and presents the IF/ID register contents (pc, instr, opcode, rs1, rs2) to decode and to the hazard unit.

---
 rtl/core_pkg.sv | 19 +
 rtl/fetch_queue.sv | 74 +++++++
 rtl/fetch_stage.sv | 169 ++++++++++++++++
 tb/tb_fetch_stage.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared RV32I core definitions: word width, the canonical NOP, the major
// opcodes the pipeline cares about and the fetch-queue entry type.
package core_pkg;

    localparam int          XLEN      = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;   // addi x0, x0, 0

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;

    // One fetched instruction together with the PC it was fetched from.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of fetch_entry_t with push, pop, clear and occupancy.
// Head is read combinationally so a pop and its data land in the same cycle.
// A simultaneous push and pop on a full queue is allowed.
module fetch_queue
    import core_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic                   push,
    input  fetch_entry_t           push_data,
    input  logic                   pop,
    output fetch_entry_t           head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full
);

    localparam int AW = $clog2(DEPTH);

    fetch_entry_t    mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic            do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (AW+1)'(DEPTH));
    assign count   = count_q;
    assign head    = mem_q[rd_ptr_q];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Pointer and occupancy update; clear discards everything at once.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            if (do_push && !do_pop)      count_d = count_q + (AW+1)'(1);
            else if (!do_push && do_pop) count_d = count_q - (AW+1)'(1);
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents need no reset because occupancy guards reads.
    always_ff @(posedge clk) begin
        if (do_push && !clear) mem_q[wr_ptr_q] <= push_data;
    end

    // Callers must never push into a full queue without popping.
    assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !pop && !clear));

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage and IF/ID register. Issues pipelined imem
// requests, tags each with its PC, buffers returned words and feeds IF/ID.
// Optional macro FETCH_PERF_CNT_EN adds stall/flush/bubble counters.
module fetch_stage
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          QDEPTH    = 2,
    parameter logic [31:0] NOP_INSTR = core_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pc_write,
    input  logic        ifid_write,
    input  logic        ifid_clear,
    input  logic        flush,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        ifid_valid,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_instr,
    output logic [6:0]  ifid_opcode,
    output logic [4:0]  ifid_rs1,
    output logic [4:0]  ifid_rs2
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_stall_cycles,
    output logic [31:0] perf_flushes,
    output logic [31:0] perf_bubbles
`endif
);

    localparam int CW = $clog2(QDEPTH) + 1;

    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] out_q, out_d;      // requests accepted but not yet answered
    logic [CW-1:0] drop_q, drop_d;    // answers still owed to flushed requests
    logic          ifid_valid_q, ifid_valid_d;
    logic [31:0]   ifid_pc_q, ifid_pc_d;
    logic [31:0]   ifid_instr_q, ifid_instr_d;

    fetch_entry_t  q_head, tag_head, rsp_entry;
    logic [CW-1:0] q_count, tag_count;
    logic          q_empty, q_full, tag_empty, tag_full;
    logic          hs, rsp_live, load_en, bypass, q_push, q_pop;

    // Issue only while the queue can absorb every in-flight answer.
    assign imem_req_valid = rst_n && pc_write && !flush &&
                            (({1'b0, out_q} + {1'b0, q_count}) < (CW+1)'(QDEPTH));
    assign imem_addr = pc_q;
    assign hs        = imem_req_valid && imem_req_ready;
    assign rsp_live  = imem_rsp_valid && (drop_q == '0);
    assign rsp_entry = '{pc: tag_head.pc, instr: imem_rsp_data};
    assign load_en   = ifid_write && !flush;
    assign bypass    = load_en && q_empty && rsp_live;
    assign q_pop     = load_en && !q_empty;
    assign q_push    = rsp_live && !flush && !bypass;

    fetch_queue #(.DEPTH(QDEPTH)) u_instr_q (
        .clk(clk), .rst_n(rst_n), .clear(flush),
        .push(q_push), .push_data(rsp_entry), .pop(q_pop),
        .head(q_head), .count(q_count), .empty(q_empty), .full(q_full)
    );

    // PC of every live request, in issue order; its instr field is unused.
    fetch_queue #(.DEPTH(QDEPTH)) u_tag_q (
        .clk(clk), .rst_n(rst_n), .clear(flush),
        .push(hs), .push_data('{pc: pc_q, instr: 32'h0}), .pop(rsp_live),
        .head(tag_head), .count(tag_count), .empty(tag_empty), .full(tag_full)
    );

    logic unused_bits;
    assign unused_bits = ^{tag_head.instr, tag_count, tag_empty, tag_full, q_full, ifid_clear};

    // Next-state for PC, in-flight and drop bookkeeping; flush has priority.
    always_comb begin
        pc_d   = pc_q;
        out_d  = out_q + CW'(hs) - CW'(imem_rsp_valid);
        drop_d = drop_q;
        if (flush) begin
            pc_d   = redirect_pc;
            drop_d = out_q - CW'(imem_rsp_valid);
        end else begin
            if (hs) pc_d = pc_q + 32'd4;
            if (imem_rsp_valid && (drop_q != '0)) drop_d = drop_q - CW'(1);
        end
    end

    // IF/ID next value: flush bubble, queue head, bypassed answer, NOP or hold.
    always_comb begin
        ifid_valid_d = ifid_valid_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_instr_d = ifid_instr_q;
        if (flush || (load_en && q_empty && !rsp_live)) begin
            ifid_valid_d = 1'b0;
            ifid_pc_d    = 32'h0;
            ifid_instr_d = NOP_INSTR;
        end else if (q_pop) begin
            ifid_valid_d = 1'b1;
            ifid_pc_d    = q_head.pc;
            ifid_instr_d = q_head.instr;
        end else if (bypass) begin
            ifid_valid_d = 1'b1;
            ifid_pc_d    = rsp_entry.pc;
            ifid_instr_d = rsp_entry.instr;
        end
    end

    // Stage registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q         <= RESET_PC;
            out_q        <= '0;
            drop_q       <= '0;
            ifid_valid_q <= 1'b0;
            ifid_pc_q    <= 32'h0;
            ifid_instr_q <= NOP_INSTR;
        end else begin
            pc_q         <= pc_d;
            out_q        <= out_d;
            drop_q       <= drop_d;
            ifid_valid_q <= ifid_valid_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_instr_q <= ifid_instr_d;
        end
    end

    assign ifid_valid  = ifid_valid_q;
    assign ifid_pc     = ifid_pc_q;
    assign ifid_instr  = ifid_instr_q;
    assign ifid_opcode = ifid_instr_q[6:0];
    assign ifid_rs1    = ifid_instr_q[19:15];
    assign ifid_rs2    = ifid_instr_q[24:20];

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;
    logic [31:0] bubble_cnt_q, bubble_cnt_d;

    // Free-running event counters, wrapping at 2^32.
    always_comb begin
        stall_cnt_d  = stall_cnt_q + 32'(!ifid_write);
        flush_cnt_d  = flush_cnt_q + 32'(flush);
        bubble_cnt_d = bubble_cnt_q + 32'(ifid_clear);
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign perf_stall_cycles = stall_cnt_q;
    assign perf_flushes      = flush_cnt_q;
    assign perf_bubbles      = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: an in-order imem model with configurable latency,
// a queue-based reference of the fetch rules checked every cycle, and
// directed scenarios with literal expectations.
module tb_fetch_stage;
    import core_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pc_write = 1'b1, ifid_write = 1'b1, ifid_clear = 1'b0, flush = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req_valid, imem_req_ready = 1'b1;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        ifid_valid;
    logic [31:0] ifid_pc, ifid_instr;
    logic [6:0]  ifid_opcode;
    logic [4:0]  ifid_rs1, ifid_rs2;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk(clk), .rst_n(rst_n), .pc_write(pc_write), .ifid_write(ifid_write),
        .ifid_clear(ifid_clear), .flush(flush), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_addr(imem_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .ifid_valid(ifid_valid), .ifid_pc(ifid_pc),
        .ifid_instr(ifid_instr), .ifid_opcode(ifid_opcode), .ifid_rs1(ifid_rs1),
        .ifid_rs2(ifid_rs2)
    );

    int checks = 0;
    int errors = 0;
    int cycle  = 0;
    int lat    = 1;
    bit rand_lat = 0;

    typedef struct { logic [31:0] addr; int due; } mreq_t;
    typedef struct { logic [31:0] addr; bit dead; } infl_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;

    mreq_t mq[$];       // memory side: accepted requests awaiting their answer
    infl_t m_infl[$];   // reference: every request in flight, flushed ones marked dead
    ent_t  m_q[$];      // reference: fetched words waiting for IF/ID
    logic [31:0] m_pc, m_if_pc, m_if_instr;
    bit          m_if_valid;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return a ^ {a[7:0], a[7:0], a[7:0], 8'h00};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0;
        m_infl.delete();
        m_q.delete();
        m_if_valid = 0;
        m_if_pc    = 32'h0;
        m_if_instr = 32'h0000_0013;
        mq.delete();
        cycle = 0;
    endtask

    // Assert reset mid-cycle, check the asynchronous values, release on negedge.
    task automatic do_reset();
        #2;
        imem_rsp_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_ifid_valid", 32'(ifid_valid), 32'd0);
        chk("rst_ifid_instr", ifid_instr, 32'h0000_0013);
        chk("rst_ifid_pc", ifid_pc, 32'h0);
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
    endtask

    function automatic int next_due();
        int d;
        d = cycle + (rand_lat ? int'($urandom_range(1, 3)) : lat);
        if (mq.size() > 0 && d <= mq[$].due) d = mq[$].due + 1;
        return d;
    endfunction

    // One clock cycle: drive memory answer, compare against reference, advance it.
    task automatic cyc();
        bit   pv, hs, live;
        ent_t e, r;
        infl_t f;
        if (mq.size() > 0 && mq[0].due <= cycle) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = word_at(mq[0].addr);
            void'(mq.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
        end
        #1;
        pv = pc_write && !flush && ((m_infl.size() + m_q.size()) < 2);
        chk("req_valid", 32'(imem_req_valid), 32'(pv));
        chk("imem_addr", imem_addr, m_pc);
        chk("ifid_valid", 32'(ifid_valid), 32'(m_if_valid));
        chk("ifid_instr", ifid_instr, m_if_instr);
        if (m_if_valid) begin
            chk("ifid_pc", ifid_pc, m_if_pc);
            chk("ifid_opcode", 32'(ifid_opcode), 32'(m_if_instr[6:0]));
            chk("ifid_rs1", 32'(ifid_rs1), 32'(m_if_instr[19:15]));
            chk("ifid_rs2", 32'(ifid_rs2), 32'(m_if_instr[24:20]));
        end
        if (imem_req_valid && imem_req_ready) mq.push_back('{addr: imem_addr, due: next_due()});

        hs   = pv && imem_req_ready;
        live = 0;
        r    = '{pc: 32'h0, instr: imem_rsp_data};
        if (imem_rsp_valid && m_infl.size() > 0) begin
            f    = m_infl.pop_front();
            live = !f.dead;
            r.pc = f.addr;
        end
        if (flush) begin
            m_pc = redirect_pc;
            m_q.delete();
            foreach (m_infl[i]) m_infl[i].dead = 1;
            m_if_valid = 0;
            m_if_pc    = 32'h0;
            m_if_instr = 32'h0000_0013;
        end else begin
            if (ifid_write) begin
                if (m_q.size() > 0) begin
                    e = m_q.pop_front();
                    m_if_valid = 1; m_if_pc = e.pc; m_if_instr = e.instr;
                    if (live) m_q.push_back(r);
                end else if (live) begin
                    m_if_valid = 1; m_if_pc = r.pc; m_if_instr = r.instr;
                end else begin
                    m_if_valid = 0; m_if_pc = 32'h0; m_if_instr = 32'h0000_0013;
                end
                if (m_if_valid) $display("cycle %0d: IF/ID load pc=%h instr=%h", cycle, m_if_pc, m_if_instr);
            end else if (live) begin
                m_q.push_back(r);
            end
            if (hs) begin
                m_infl.push_back('{addr: m_pc, dead: 0});
                m_pc = m_pc + 32'd4;
            end
        end
        @(negedge clk);
        cycle++;
    endtask

    task automatic cycn(input int n);
        for (int k = 0; k < n; k++) cyc();
    endtask

    task automatic lit_pc(input string name, input logic [31:0] exp);
        chk({name, "_dut"}, ifid_pc, exp);
        chk({name, "_model"}, m_if_pc, exp);
        chk({name, "_valid"}, 32'(ifid_valid), 32'd1);
    endtask

    // Run until IF/ID holds a real instruction; returns cycles spent.
    task automatic wait_valid(input string name, output int n);
        n = 0;
        while (!ifid_valid && n < 20) begin
            cyc();
            n++;
        end
        if (!ifid_valid) chk({name, "_timeout"}, 32'(ifid_valid), 32'd1);
    endtask

    initial begin
        int n;
        @(negedge clk);

        // Streaming then a three-cycle stall at ifid_pc=0x8.
        lat = 1;
        do_reset();
        #1;
        chk("A_first_addr", imem_addr, 32'h0);
        chk("A_first_valid", 32'(imem_req_valid), 32'd1);
        cycn(2); lit_pc("A_pc0", 32'h0);
        cyc();   lit_pc("A_pc4", 32'h4);
        cyc();   lit_pc("A_pc8", 32'h8);
        chk("A_instr8", ifid_instr, 32'h0808_0808);
        pc_write = 0; ifid_write = 0;
        cycn(3); lit_pc("A_hold8", 32'h8);
        pc_write = 1; ifid_write = 1;
        cyc();   lit_pc("A_pcC", 32'hC);
        chk("A_instrC", ifid_instr, 32'h0C0C_0C0C);
        cycn(4);

        // Backpressure: ready low four cycles with address 0x10 pending.
        do_reset();
        cycn(4);
        imem_req_ready = 0;
        for (int k = 0; k < 4; k++) begin
            chk("B_addr_stable", imem_addr, 32'h10);
            cyc();
        end
        imem_req_ready = 1;
        cycn(2); lit_pc("B_pc10", 32'h10);
        cycn(3);

        // Flush with two requests in flight (latency 3).
        lat = 3;
        do_reset();
        cycn(2);
        flush = 1; redirect_pc = 32'h100;
        cyc();
        flush = 0;
        chk("C_flush_valid", 32'(ifid_valid), 32'd0);
        chk("C_flush_instr", ifid_instr, 32'h0000_0013);
        wait_valid("C", n);
        chk("C_wait_cycles", 32'(n), 32'd5);
        lit_pc("C_pc100", 32'h100);
        cycn(4);

        // Back-to-back flushes: the later target wins.
        do_reset();
        cycn(2);
        flush = 1; redirect_pc = 32'h200; cyc();
        redirect_pc = 32'h300; cyc();
        flush = 0;
        wait_valid("E", n);
        lit_pc("E_pc300", 32'h300);
        cycn(3);

        // Flush while stalled (latency 1).
        lat = 1;
        do_reset();
        cycn(3);
        pc_write = 0; ifid_write = 0; flush = 1; redirect_pc = 32'h40;
        cyc();
        pc_write = 1; ifid_write = 1; flush = 0;
        #1;
        chk("D_addr40", imem_addr, 32'h40);
        chk("D_req_valid", 32'(imem_req_valid), 32'd1);
        chk("D_ifid_valid", 32'(ifid_valid), 32'd0);
        chk("D_ifid_instr", ifid_instr, 32'h0000_0013);
        cycn(2); lit_pc("D_pc40", 32'h40);

        // Mixed traffic with random stalls, backpressure, flushes and a mid-run reset.
        rand_lat = 1;
        for (int i = 0; i < 200; i++) begin
            if (i == 100) do_reset();
            pc_write       = ($urandom_range(0, 9) < 8);
            ifid_write     = ($urandom_range(0, 9) < 8);
            imem_req_ready = ($urandom_range(0, 3) != 0);
            ifid_clear     = $urandom_range(0, 1);
            flush          = ($urandom_range(0, 19) == 0);
            redirect_pc    = {20'h0, 4'($urandom_range(0, 15)), 8'h00} + 32'h1000;
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
